// File: rtl/data_concentrator_q.sv
// Configuration/service concentrator with queued records and optional TMR on
// the FIFO pointers and occupancy counts.
module data_concentrator_q #(
  parameter int          CONF_DEPTH = 4,
  parameter int          SER_DEPTH  = 4,
  parameter int          TMR        = 1,
  parameter logic [7:0]  HDR_ADDR   = 8'hEA,
  parameter logic [7:0]  HDR_DATA   = 8'hEC,
  parameter logic [7:0]  HDR_SER    = 8'hEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [6:0]  Column,
  input  logic [8:0]  Row,
  input  logic [3:0]  TotTop,
  input  logic [3:0]  TotBottom,
  input  logic [15:0] Conf_Data,
  input  logic [15:0] Conf_Address,
  input  logic        Conf_Write,
  input  logic        Conf_Addr_Enable,
  output logic        Conf_Free,
  output logic        Write_Conf_Req,
  input  logic        Write_Conf,
  input  logic        Write_Service,
  input  logic [15:0] Ser_Data,
  output logic        W_Req_Ser,
  input  logic        Write_Ser_Req,
  output logic        Overflow,
  input  logic        Clear_Ovf,
  output logic [7:0]  Word0,
  output logic [7:0]  Word1,
  output logic [7:0]  Word2
);

  localparam int CPW  = $clog2(CONF_DEPTH);
  localparam int CCW  = $clog2(CONF_DEPTH + 1);
  localparam int SPW  = (SER_DEPTH > 1) ? $clog2(SER_DEPTH) : 1;
  localparam int SCW  = $clog2(SER_DEPTH + 1);
  localparam int ST_W = 2 * CPW + CCW + 2 * SPW + SCW;

  // Entry bit 16 is the record type: 1 = address record, 0 = data record.
  logic [16:0] c_mem [CONF_DEPTH];
  logic [15:0] s_mem [SER_DEPTH];

  logic [ST_W-1:0] st_q0, st_q1, st_q2, st_v, st_n;

  logic [CPW-1:0] c_wr, c_rd, c_wr_n, c_rd_n;
  logic [CCW-1:0] c_cnt, c_cnt_n, c_need, c_free;
  logic [SPW-1:0] s_wr, s_rd, s_wr_n, s_rd_n;
  logic [SCW-1:0] s_cnt, s_cnt_n;

  logic ser_pop, conf_pop, conf_push, ser_push, drop;
  logic [16:0] c_head;
  logic [15:0] s_head;

  function automatic logic [SPW-1:0] s_inc(input logic [SPW-1:0] p);
    return (p == SPW'(SER_DEPTH - 1)) ? '0 : p + SPW'(1);
  endfunction

  // With TMR=0 the spare copies alias the primary, so the vote is a pass-through.
  assign st_v = (st_q0 & st_q1) | (st_q0 & st_q2) | (st_q1 & st_q2);
  assign {c_wr, c_rd, c_cnt, s_wr, s_rd, s_cnt} = st_v;
  assign st_n = {c_wr_n, c_rd_n, c_cnt_n, s_wr_n, s_rd_n, s_cnt_n};

  assign c_head = c_mem[c_rd];
  assign s_head = s_mem[s_rd];

  always_comb begin
    ser_pop   = Write_Ser_Req && (s_cnt != '0);
    conf_pop  = Write_Conf && (c_cnt != '0) && !ser_pop;
    c_need    = Conf_Addr_Enable ? CCW'(2) : CCW'(1);
    // A slot vacated by this cycle's pop counts as free.
    c_free    = CCW'(CONF_DEPTH) - c_cnt + CCW'(conf_pop);
    conf_push = Conf_Write && (c_free >= c_need);
    ser_push  = Write_Service && ((s_cnt != SCW'(SER_DEPTH)) || ser_pop);
    drop      = (Conf_Write && !conf_push) || (Write_Service && !ser_push);

    c_wr_n  = conf_push ? c_wr + CPW'(c_need) : c_wr;
    c_rd_n  = c_rd + CPW'(conf_pop);
    c_cnt_n = c_cnt + (conf_push ? c_need : '0) - CCW'(conf_pop);
    s_wr_n  = ser_push ? s_inc(s_wr) : s_wr;
    s_rd_n  = ser_pop ? s_inc(s_rd) : s_rd;
    s_cnt_n = s_cnt + SCW'(ser_push) - SCW'(ser_pop);

    Word0 = {Column, Row[8]};
    Word1 = Row[7:0];
    Word2 = {TotTop, TotBottom};
    if (ser_pop) begin
      Word0 = HDR_SER;
      Word1 = s_head[15:8];
      Word2 = s_head[7:0];
    end else if (conf_pop) begin
      Word0 = c_head[16] ? HDR_ADDR : HDR_DATA;
      Word1 = c_head[15:8];
      Word2 = c_head[7:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (conf_push) begin
      if (Conf_Addr_Enable) begin
        c_mem[c_wr]           <= {1'b1, Conf_Address};
        c_mem[c_wr + CPW'(1)] <= {1'b0, Conf_Data};
      end else begin
        c_mem[c_wr] <= {1'b0, Conf_Data};
      end
    end
    if (ser_push) s_mem[s_wr] <= Ser_Data;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      st_q0    <= '0;
      Overflow <= 1'b0;
    end else begin
      st_q0 <= st_n;
      if (drop)           Overflow <= 1'b1;
      else if (Clear_Ovf) Overflow <= 1'b0;
    end
  end

  generate
    if (TMR != 0) begin : g_tmr
      always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
          st_q1 <= '0;
          st_q2 <= '0;
        end else begin
          st_q1 <= st_n;
          st_q2 <= st_n;
        end
      end
    end else begin : g_single
      assign st_q1 = st_q0;
      assign st_q2 = st_q0;
    end
  endgenerate

  assign Conf_Free      = (c_cnt <= CCW'(CONF_DEPTH - 2));
  assign Write_Conf_Req = (c_cnt != '0);
  assign W_Req_Ser      = (s_cnt != '0);

endmodule

// File: doc/data_concentrator_q.md
Name: data_concentrator_q

Overview:
- Parametrised successor to the single-slot configuration/service concentrator in the FE read-out path.
- Queues configuration address/data records and service records in two small FIFOs, so back-to-back Conf_Write and Write_Service pulses are not lost while the serializer is busy.
- Multiplexes the head record, or live hit data, onto three output words: header/high byte, mid byte, low byte.
- Optional triple-redundant storage of the FIFO pointers and occupancy, with majority voting.

Parameters:
CONF_DEPTH, 4, entries in the configuration FIFO (power of 2, >=2); one entry = 1 bit type + 16 bit payload
SER_DEPTH, 4, entries in the service FIFO (power of 2, >=1)
TMR, 1, 1 = triplicate pointers/counts with 2-of-3 vote and refresh every cycle; 0 = single copy
HDR_ADDR, 8'hEA, Word0 header for a configuration-address record
HDR_DATA, 8'hEC, Word0 header for a configuration-data record
HDR_SER, 8'hEF, Word0 header for a service record

Ports:
Clk  in  1  clock, all state on rising edge
Reset  in  1  asynchronous, active-low reset
Column  in  7  hit column
Row  in  9  hit row
TotTop  in  4  ToT of top pixel
TotBottom  in  4  ToT of bottom pixel
Conf_Data  in  16  configuration data
Conf_Address  in  16  configuration address
Conf_Write  in  1  one-cycle push strobe for a configuration write
Conf_Addr_Enable  in  1  with Conf_Write: also queue an address record ahead of the data record
Conf_Free  out  1  configuration FIFO has >=2 free entries
Write_Conf_Req  out  1  configuration FIFO non-empty
Write_Conf  in  1  serializer takes the configuration head this cycle
Write_Service  in  1  one-cycle push strobe for a service record
Ser_Data  in  16  service payload, sampled on the Write_Service edge
W_Req_Ser  out  1  service FIFO non-empty
Write_Ser_Req  in  1  serializer takes the service head this cycle
Overflow  out  1  sticky: a push was dropped
Clear_Ovf  in  1  synchronous clear of Overflow
Word0  out  8  output byte 0
Word1  out  8  output byte 1
Word2  out  8  output byte 2

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - Both FIFOs are emptied and Overflow=0.
  - Outputs: Conf_Free=1, Write_Conf_Req=0, W_Req_Ser=0.
  - Word0..2 fall to the hit mapping.
- Configuration push (Conf_Write=1):
  - With Conf_Addr_Enable=1: queue {addr, Conf_Address} then {data, Conf_Data}, preserving that order. Needs 2 free entries.
  - With Conf_Addr_Enable=0: queue {data, Conf_Data} only. Needs 1 free entry.
  - Free-entry count includes a slot released by a same-cycle pop.
  - Insufficient space: the whole write is dropped (no partial pair) and Overflow sets.
- Service push (Write_Service=1):
  - Queues Ser_Data.
  - If the FIFO is full with no same-cycle pop, the push is dropped and Overflow sets.
- Requests: Write_Conf_Req and W_Req_Ser are registered-state decodes of count != 0. A pushed record is requested from the cycle after the push edge.
- Selection (combinational, priority order):
  1. Write_Ser_Req=1 and service FIFO non-empty: Word0=HDR_SER, Word1=head[15:8], Word2=head[7:0]. Service head pops at the edge.
  2. Else Write_Conf=1 and configuration FIFO non-empty: Word0=HDR_ADDR or HDR_DATA according to the head type bit, Word1/Word2 = payload bytes. Configuration head pops at the edge.
  3. Otherwise, the hit mapping: Word0={Column,Row[8]}, Word1=Row[7:0], Word2={TotTop,TotBottom}.
- Grant with empty FIFO: Write_Ser_Req or Write_Conf asserted while the matching FIFO is empty pops nothing, and the next lower priority source applies.
- Simultaneous grants: when Write_Ser_Req and Write_Conf are both high, only the service record is output and popped; the configuration head stays.
- Push and pop in the same cycle: count is unchanged and ordering is preserved.
- Pointers wrap modulo depth. Count width is clog2(depth+1).
- Overflow:
  - Clear_Ovf in the same cycle as a new drop leaves Overflow=1.
  - Otherwise Clear_Ovf gives 0 at the next edge.
- TMR=1:
  - Every pointer/count bit is held in three registers.
  - All logic uses the vote, and all three copies reload from voted next-state each cycle.
  - A single upset copy is corrected within one cycle with no visible output change.
- Latency:
  - Push to request: 1 cycle.
  - Grant to Word output: combinational (0 cycles).
  - Pop takes effect at the grant edge.

Test Plan:
1. Reset, then Conf_Write with Conf_Addr_Enable=1, Conf_Address=16'h1234, Conf_Data=16'hABCD -> next cycle Write_Conf_Req=1. First Write_Conf gives Words EA/12/34, second gives EC/AB/CD. After that Write_Conf_Req=0 and Conf_Free=1.
2. CONF_DEPTH=4: three data-only writes (01 02 03) then an address write -> the address write is dropped whole and Overflow=1. A following pop gives 3 data records in order. Clear_Ovf -> Overflow=0.
3. Write_Service with Ser_Data=16'h5A5A while a configuration record is pending, then Write_Ser_Req=1 and Write_Conf=1 together -> Words EF/5A/5A. The service FIFO empties; Write_Conf_Req stays 1.
4. No grants; Column=7'h55, Row=9'h1C3, TotTop=4'h9, TotBottom=4'h2 -> Words AB/C3/92.
5. Push and pop on a full service FIFO in the same cycle -> no Overflow, count stays SER_DEPTH, FIFO order is intact.
6. TMR=1: force one copy of the configuration write pointer wrong for a cycle -> corrected next cycle and the record sequence is unchanged. Asynchronous Reset pulse mid-sequence -> both FIFOs empty and Words show hit data immediately.
